// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared state encoding and default halt opcode for the fetch unit.
// Rev    : 1.0
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } fetch_state_t;

  localparam logic [7:0] c_default_halt_opcode = 8'h00;

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module : fetch_if
// Brief  : Controller <-> fetch unit bus (control, program load, fetch outputs).
// Rev    : 1.0
// ============================================================================
interface fetch_if #(
  parameter int ADDR_WIDTH  = 3,
  parameter int INSTR_WIDTH = 8
);
  logic                   start;
  logic                   increment;
  logic                   jump;
  logic [ADDR_WIDTH-1:0]  jump_address;
  logic                   prog_we;
  logic [ADDR_WIDTH-1:0]  prog_addr;
  logic [INSTR_WIDTH-1:0] prog_data;
  logic [INSTR_WIDTH-1:0] instruction;
  logic [ADDR_WIDTH-1:0]  instruction_address;
  logic                   valid;
  logic                   halted;
  logic                   addr_error;

  modport master (
    output start, increment, jump, jump_address, prog_we, prog_addr, prog_data,
    input  instruction, instruction_address, valid, halted, addr_error
  );

  modport slave (
    input  start, increment, jump, jump_address, prog_we, prog_addr, prog_data,
    output instruction, instruction_address, valid, halted, addr_error
  );
endinterface
`default_nettype wire

// File: rtl/instruction_memory.sv
`default_nettype none
// ============================================================================
// Module : instruction_memory
// Brief  : DEPTH x INSTR_WIDTH array, synchronous write, asynchronous read.
// Rev    : 1.0
// ============================================================================
module instruction_memory #(
  parameter int INSTR_WIDTH = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int DEPTH       = 8
) (
  input  wire logic                   clk,
  input  wire logic                   i_we,
  input  wire logic [ADDR_WIDTH-1:0]  i_waddr,
  input  wire logic [INSTR_WIDTH-1:0] i_wdata,
  input  wire logic [ADDR_WIDTH-1:0]  i_raddr,
  output      logic [INSTR_WIDTH-1:0] o_rdata
);
  localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH + 1)'(DEPTH);

  // Contents are deliberately not reset so a loaded program survives reset.
  logic [INSTR_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = ({1'b0, i_raddr} < c_depth) ? r_mem[i_raddr] : '0;
endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : instruction_fetch_unit
// Brief  : Program counter FSM with loadable instruction memory, jump and halt.
// Rev    : 1.0
// ============================================================================
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int INSTR_WIDTH = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int DEPTH       = 8,
  parameter int WRAP        = 1,
  parameter int HALT_EN     = 1,
  parameter logic [INSTR_WIDTH-1:0] HALT_OPCODE = INSTR_WIDTH'(c_default_halt_opcode)
) (
  input wire logic clock,
  input wire logic resetnot,
  fetch_if.slave   bus
);
  localparam logic [ADDR_WIDTH:0]   c_depth     = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(DEPTH - 1);
  localparam bit                    c_wrap      = (WRAP != 0);
  localparam bit                    c_halt_en   = (HALT_EN != 0);

  fetch_state_t           r_state;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic                   r_valid;
  logic                   r_halted;
  logic                   r_addr_error;

  logic [INSTR_WIDTH-1:0] w_rdata;
  logic                   w_prog_in_range;
  logic                   w_jump_in_range;
  logic                   w_halt_hit;
  logic                   w_mem_we;

  assign w_prog_in_range = ({1'b0, bus.prog_addr} < c_depth);
  assign w_jump_in_range = ({1'b0, bus.jump_address} < c_depth);
  assign w_halt_hit      = c_halt_en && (w_rdata == HALT_OPCODE);
  assign w_mem_we        = bus.prog_we && (r_state != RUN) && w_prog_in_range;

  instruction_memory #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DEPTH       (DEPTH)
  ) u_mem (
    .clk     (clock),
    .i_we    (w_mem_we),
    .i_waddr (bus.prog_addr),
    .i_wdata (bus.prog_data),
    .i_raddr (r_pc),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock or negedge resetnot) begin
    if (!resetnot) begin
      r_state      <= IDLE;
      r_pc         <= '0;
      r_valid      <= 1'b0;
      r_halted     <= 1'b0;
      r_addr_error <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          // Halt check sees the word at the current pc, including the first RUN cycle.
          if (w_halt_hit) begin
            r_state  <= HALTED;
            r_valid  <= 1'b0;
            r_halted <= 1'b1;
          end else if (bus.jump) begin
            if (w_jump_in_range) begin
              r_pc <= bus.jump_address;
            end else begin
              r_addr_error <= 1'b1;
              r_state      <= HALTED;
              r_valid      <= 1'b0;
              r_halted     <= 1'b1;
            end
          end else if (bus.increment) begin
            if (r_pc != c_last_addr) begin
              r_pc <= r_pc + ADDR_WIDTH'(1);
            end else if (c_wrap) begin
              r_pc <= '0;
            end else begin
              r_state  <= HALTED;
              r_valid  <= 1'b0;
              r_halted <= 1'b1;
            end
          end
        end
        default: begin
          if (bus.prog_we && !w_prog_in_range) begin
            r_addr_error <= 1'b1;
          end
          if (bus.start) begin
            r_state  <= RUN;
            r_pc     <= '0;
            r_valid  <= 1'b1;
            r_halted <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.instruction         = r_valid ? w_rdata : '0;
  assign bus.instruction_address = r_pc;
  assign bus.valid               = r_valid;
  assign bus.halted              = r_halted;
  assign bus.addr_error          = r_addr_error;
endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Parametrised program counter plus instruction memory. It replaces the fixed 4-entry, increment-only fetch logic in front of the controller.
- Adds a program-load port, jumps, a halt opcode, configurable end-of-program wrap/halt, and an address-error flag.
- Sits between the controller, which drives increment/jump, and the controller/datapath, which consume instruction.
- All state advances on clock; increment is a level-sampled enable, never a clock.

Parameters:
INSTR_WIDTH, 8, instruction word width
ADDR_WIDTH, 3, program counter width
DEPTH, 8, number of memory words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH
WRAP, 1, 1: increment at DEPTH-1 wraps to 0; 0: increment at DEPTH-1 enters HALTED
HALT_EN, 1, 1: fetching HALT_OPCODE halts the unit
HALT_OPCODE, 8'h00, opcode that halts (INSTR_WIDTH bits)

Ports:
clock  input  1  system clock, rising edge
resetnot  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse: IDLE/HALTED -> RUN with pc=0
increment  input  1  advance pc by 1 this cycle (RUN only)
jump  input  1  load pc from jump_address this cycle (RUN only)
jump_address  input  ADDR_WIDTH  jump target
prog_we  input  1  program write strobe
prog_addr  input  ADDR_WIDTH  program write address
prog_data  input  INSTR_WIDTH  program write data
instruction  output  INSTR_WIDTH  mem[pc]; all zeros when not RUN
instruction_address  output  ADDR_WIDTH  current pc
valid  output  1  high in RUN: instruction is current
halted  output  1  high in HALTED
addr_error  output  1  sticky out-of-range flag

Behaviour:
- Clock and reset: one clock, clock. Reset is resetnot, asynchronous and active-low.
- Reset values:
  - state=IDLE, pc=0, addr_error=0, valid=0, halted=0, instruction=0.
  - Memory contents are not reset; they persist across reset.
- States:
  - IDLE: start -> RUN.
  - RUN: halt condition -> HALTED.
  - HALTED: start -> RUN.
  - No other transitions.
- Program writes:
  - prog_we is accepted in IDLE and HALTED: mem[prog_addr] <= prog_data at the clock edge.
  - prog_we is ignored in RUN.
  - prog_addr >= DEPTH: write dropped and addr_error set.
- Fetch:
  - instruction = mem[pc], a combinational read of the registered pc, so zero latency from a pc update.
  - A write to mem[pc] while not RUN is visible immediately after that edge.
- start:
  - Sets pc=0 and enters RUN on the same edge.
  - Ignored while in RUN.
- In RUN, per edge, in priority order:
  1. Halt check. If HALT_EN and instruction==HALT_OPCODE, go to HALTED; pc holds; increment and jump are ignored.
  2. jump:
     - jump_address < DEPTH: pc <= jump_address.
     - Otherwise: addr_error <= 1, state <= HALTED, pc holds.
  3. increment:
     - pc < DEPTH-1: pc <= pc+1.
     - pc == DEPTH-1 and WRAP=1: pc <= 0.
     - pc == DEPTH-1 and WRAP=0: go to HALTED, pc holds.
  4. Otherwise pc holds.
- Simultaneous jump and increment: jump wins; increment is discarded, not queued.
- A HALT_OPCODE at pc is seen on the first RUN cycle, so the halt check applies to it. Example: start with mem[0]==HALT_OPCODE gives one RUN cycle with valid=1, then HALTED.
- HALTED:
  - instruction_address keeps the last pc; instruction=0, valid=0, halted=1.
- addr_error:
  - Cleared only by reset.
  - Does not block a later start.
- Reset mid-RUN: immediate return to IDLE, pc=0, outputs at reset values; the program is retained.
- Width rules:
  - pc arithmetic is ADDR_WIDTH bits.
  - With DEPTH == 2**ADDR_WIDTH, wrap is natural overflow and addr_error can never be set.

Decomposition:
- Shared package (fetch_pkg): state encoding typedef (IDLE=2'b00, RUN=2'b01, HALTED=2'b10) and the default HALT_OPCODE constant.
- One natural sub-module: instruction_memory. It holds the DEPTH x INSTR_WIDTH array, with a synchronous write port and an asynchronous read port, parametrised identically.
- The pc register and FSM stay in the top module.

Test Plan:
1. Defaults, HALT_EN=0. Load 10110001, 11010111, 00000101, 01010110 at addresses 0-3; start; increment four cycles -> instruction_address 0,1,2,3,4 with instruction matching; valid=1 throughout.
2. WRAP=1, DEPTH=8, HALT_EN=0. Start, hold increment for 9 cycles -> pc sequence 0..7,0,1; halted stays 0. Repeat with WRAP=0 -> after pc=7 and one more increment, halted=1, instruction_address=7, instruction=0.
3. Load mem[2]=8'h00 (HALT_EN=1). Start; increment, increment -> pc=2, halted=1 next edge. Assert increment in HALTED -> pc stays 2. Pulse start -> pc=0, valid=1.
4. DEPTH=6, ADDR_WIDTH=3. In RUN, assert jump with jump_address=4 and increment in the same cycle -> pc=4. Then jump_address=7 -> addr_error=1, halted=1, pc=4. Also prog_we with prog_addr=6 -> write dropped, addr_error=1.
5. Assert prog_we to address 1 during RUN -> mem[1] unchanged, verified after halting by reading instruction at pc=1 after a restart.
6. Deassert resetnot asynchronously mid-cycle while pc=3 -> outputs go to reset values immediately, without a clock edge. Then start -> the program fetched is unchanged.
